// File: rtl/signal_cutter.sv
// Rising-edge pulse generator with optional input synchronizer and, when
// SIGNAL_CUTTER_DEBOUNCE_EN is defined, a saturating high-level debounce filter.
module signal_cutter #(
    parameter int SYNC_STAGES     = 0,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);

    generate
        if (SYNC_STAGES < 0 || SYNC_STAGES > 3 ||
            DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_param
            $error("signal_cutter: parameter out of range");
        end
    endgenerate

    logic c;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign c = in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync;

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync <= '0;
                end else begin
                    sync[0] <= in;
                    for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
                end
            end

            assign c = sync[SYNC_STAGES-1];
        end
    endgenerate

    // lvl is the level whose rising edge is reported; lvl_q is its last-cycle copy.
    logic lvl;
    logic lvl_q;

`ifdef SIGNAL_CUTTER_DEBOUNCE_EN
    localparam logic [7:0] DB_LIM = 8'(DEBOUNCE_CYCLES);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || !c) cnt <= 8'd0;
        else if (cnt != 8'hFF) cnt <= cnt + 8'd1;
    end

    assign lvl = (cnt >= DB_LIM);
`else
    assign lvl = c;
`endif

    always_ff @(posedge clk) begin
        if (reset) lvl_q <= 1'b0;
        else lvl_q <= lvl;
    end

    assign out = !reset && lvl && !lvl_q;

endmodule

// File: tb/tb_signal_cutter.sv
// Bench for signal_cutter: SYNC_STAGES=0 and 2 instances on shared stimulus,
// vector table plus multi-cycle run sequences and a random tail checked by a window model.
module tb_signal_cutter;

`ifdef SIGNAL_CUTTER_DEBOUNCE_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif
    localparam int DBC = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in = 1'b0;
    logic out0, out2;

    always #5 clk = ~clk;

    signal_cutter #(.SYNC_STAGES(0), .DEBOUNCE_CYCLES(DBC)) u_s0 (
        .clk(clk), .reset(reset), .in(in), .out(out0));
    signal_cutter #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(DBC)) u_s2 (
        .clk(clk), .reset(reset), .in(in), .out(out2));

    typedef struct packed {logic rst; logic in; logic e0; logic e2;} vec_t;
    typedef struct packed {logic e0; logic e2;} exp_t;

    exp_t sb[$];
    bit   hr[$];
    bit   hi[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    bit   o0, o2;

    // c at cycle k: in from s cycles ago, zeroed if any reset in the chain window.
    function automatic bit c_at(int s, int k);
        if (k - s < 0) return 1'b0;
        for (int j = k - s; j < k; j++) if (hr[j]) return 1'b0;
        return hi[k-s];
    endfunction

    function automatic bit lvl_at(int s, int k);
        if (k < 0) return 1'b0;
        if (DB) begin
            for (int j = k - DBC; j < k; j++)
                if (j < 0 || hr[j] || !c_at(s, j)) return 1'b0;
            return 1'b1;
        end
        return c_at(s, k);
    endfunction

    function automatic bit model(int s, int k);
        bit prv;
        prv = (k < 1 || hr[k-1]) ? 1'b0 : lvl_at(s, k - 1);
        return !hr[k] && lvl_at(s, k) && !prv;
    endfunction

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, act, exp);
    endtask

    task automatic step(input logic r, input logic i, input logic e0, input logic e2,
                        input bit use_model, input string tag);
        exp_t x;
        @(posedge clk);
        #1;
        reset = r;
        in    = i;
        hr.push_back(r);
        hi.push_back(i);
        if (use_model) begin
            x.e0 = model(0, cyc);
            x.e2 = model(2, cyc);
        end else begin
            x.e0 = e0;
            x.e2 = e2;
        end
        sb.push_back(x);
        @(negedge clk);
        x  = sb.pop_front();
        o0 = out0;
        o2 = out2;
        check({tag, "_s0"}, int'(o0), int'(x.e0));
        check({tag, "_s2"}, int'(o2), int'(x.e2));
        cyc++;
    endtask

    // High run of len cycles followed by a low tail; checks pulse count and latency.
    task automatic run(input int len, input string tag);
        int cnt0, cnt2, first0, first2, ecnt;
        cnt0 = 0; cnt2 = 0; first0 = -1; first2 = -1;
        for (int i = 0; i < len + 10; i++) begin
            step(1'b0, logic'(i < len), 1'b0, 1'b0, 1'b1, tag);
            if (o0) begin cnt0++; if (first0 < 0) first0 = i; end
            if (o2) begin cnt2++; if (first2 < 0) first2 = i; end
        end
        ecnt = DB ? ((len >= DBC) ? 1 : 0) : 1;
        check({tag, "_cnt_s0"}, cnt0, ecnt);
        check({tag, "_cnt_s2"}, cnt2, ecnt);
        if (ecnt == 1) begin
            check({tag, "_lat_s0"}, first0, DB ? DBC : 0);
            check({tag, "_lat_s2"}, first2, DB ? DBC + 2 : 2);
        end
    endtask

    vec_t tbl [41];

    initial begin
        // {rst, in, exp SYNC=0, exp SYNC=2} for the non-debounce build
        tbl = '{
            4'b1000, 4'b1000, 4'b0110, 4'b0100, 4'b0101, 4'b0000, 4'b0110, 4'b0000,
            4'b0001, 4'b0110, 4'b0000, 4'b0001, 4'b0000, 4'b1100, 4'b1100, 4'b1100,
            4'b0110, 4'b0100, 4'b0101, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0110,
            4'b0100, 4'b0101, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0110, 4'b1000,
            4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0110, 4'b0000, 4'b0001,
            4'b0000};

        for (int k = 0; k < 41; k++)
            step(tbl[k].rst, tbl[k].in, tbl[k].e0, tbl[k].e2, DB, $sformatf("vec%0d", k));

        run(3, "run3");
        run(6, "run6");
        run(20, "hold20");
        run(1, "pulse1");

        for (int k = 0; k < 80; k++)
            step(logic'($urandom_range(0, 19) == 0), logic'($urandom_range(0, 1)),
                 1'b0, 1'b0, 1'b1, "rand");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/signal_cutter.md
SIGNAL_CUTTER -- requirements
Module: signal_cutter

Interface
REQ-001 Parameter SYNC_STAGES, default 0: number of flip-flop synchronizer stages inserted ahead of edge detection, legal range 0..3.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive-high cycles required before an edge is accepted, used only when SIGNAL_CUTTER_DEBOUNCE_EN is defined, legal range 1..255.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port in  input  1  level signal, possibly held high for many cycles.
REQ-006 Port out  output  1  single-cycle pulse marking each accepted rising edge of in.

Function
REQ-007 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-008 Conditioned input c:
- With SYNC_STAGES=0, c SHALL be in itself.
- With SYNC_STAGES=N>0, c SHALL be in delayed through N registers.
REQ-009 A register prev SHALL hold c from the previous clock cycle.
REQ-010 Without debounce, out SHALL equal c AND NOT prev.
- With SYNC_STAGES=0 this is combinational from in, giving zero-cycle latency: out rises in the same cycle in rises.
REQ-011 A high level held for K>=1 cycles SHALL produce exactly one out pulse, of exactly one cycle, in the first high cycle.
REQ-012 A one-cycle high pulse on in SHALL produce a one-cycle out pulse.
REQ-013 Two high pulses separated by at least one low cycle SHALL produce two out pulses.
REQ-014 A continuously low in SHALL never produce out=1.
REQ-015 out SHALL be glitch-free with respect to register state: the only combinational term is c.
REQ-016 The total out-pulse latency from in rising SHALL be SYNC_STAGES cycles without debounce.

Reset
REQ-017 While reset=1: all synchronizer stages, prev and the debounce counter SHALL load 0, and out SHALL be forced to 0.
REQ-018 If in is high in the first cycle after reset deasserts, that SHALL count as a rising edge and produce one pulse, after any synchronizer or debounce delay.
REQ-019 Reset asserted mid-pulse or mid-debounce SHALL abort it; no pulse is emitted for that edge during reset.

Configuration
REQ-020 Macro SIGNAL_CUTTER_DEBOUNCE_EN SHALL select debounce filtering.
REQ-021 When SIGNAL_CUTTER_DEBOUNCE_EN is defined:
- An 8-bit counter SHALL increment (saturating) while c=1 and clear to 0 when c=0.
- Filtered level f SHALL be 1 when the counter reaches DEBOUNCE_CYCLES.
- out SHALL equal f AND NOT the previous f.
- Latency SHALL be SYNC_STAGES+DEBOUNCE_CYCLES cycles.
- A high run shorter than DEBOUNCE_CYCLES SHALL produce no pulse.
REQ-022 When SIGNAL_CUTTER_DEBOUNCE_EN is undefined, no counter SHALL be synthesized and REQ-010 applies unchanged.

Verification
REQ-023 SYNC_STAGES=0, no macro: reset 1 cycle with in=0, then in=1 for 3 cycles -> out=1 in the first of those cycles only, 0 afterwards.
REQ-024 SYNC_STAGES=0, no macro: in pattern 1,0,0,1,0 -> out pattern 1,0,0,1,0.
REQ-025 SYNC_STAGES=2, no macro: in rises at cycle 10 and stays high -> out=1 only at cycle 12.
REQ-026 in=1 held through reset, reset released at cycle 5 -> out=0 during reset, then exactly one pulse at cycle 5 (SYNC_STAGES=0).
REQ-027 Macro defined, DEBOUNCE_CYCLES=4:
- High run of 3 cycles -> no pulse.
- High run of 6 cycles -> exactly one pulse, 4 cycles after the rise.
REQ-028 Reset asserted one cycle after in rises with SYNC_STAGES=2 -> no pulse is emitted; out stays 0 until a new rising edge.
